mul_acc: RTL and testbench

Product accumulator sitting directly downstream of the `mul` stage. It consumes one unsigned product per valid/ready handshake and sums a group of up to `N_ACC` products. It emits the group sum, the count of terms and an overflow flag on a registered output handshake, then clears for the next group. Used as the reduction half of the multiply-accumulate path.

---
 rtl/mul_acc.sv | 141 ++++++++++++++
 tb/tb_mul_acc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_acc.sv
// mul_acc: sums a group of up to N_ACC unsigned products from the mul stage and emits the
//   group sum, term count and sticky overflow flag on a registered output handshake.
// Latency: the closing input handshake at edge k raises out_valid after edge k; one idle
//   HOLD cycle minimum per group, so at most one group per N_ACC+1 cycles.
// Backpressure: in_ready drops while a result is held; in_ready never depends on out_ready.
//
// Optional feature: define MUL_ACC_SAT_EN to saturate the sum at 2^AW-1 instead of wrapping.
//
// Ports:
//   clk, reset             single clock; asynchronous active-high reset
//   in_valid/in_ready      product handshake; in_prod (PW bits), in_last closes the group early
//   out_valid/out_ready    result handshake; out_sum (AW), out_cnt (CW, 1..N_ACC), out_ovf
module mul_acc #(
   parameter int PW    = 8,
   parameter int AW    = 16,
   parameter int N_ACC = 4,
   localparam int CW   = $clog2(N_ACC + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_prod,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic [CW-1:0] out_cnt,
   output logic          out_ovf
);

   // Zero-extension width for the product; AW >= PW keeps this at least 1.
   localparam int PAD = AW + 1 - PW;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic          ovf;

   logic [AW:0]   sum_ext;
   logic          carry;
   logic [AW-1:0] acc_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          ovf_nxt;
   logic          close_cond;
   logic          in_hs;
   logic          out_hs;

   // ------------------------------------------------------------------
   // Adder: one extra bit so the carry out of bit AW-1 is visible.
   // ------------------------------------------------------------------
   always_comb begin
      sum_ext = {1'b0, acc} + {{PAD{1'b0}}, in_prod};
      carry   = sum_ext[AW];
`ifdef MUL_ACC_SAT_EN
      // Once acc sits at all-ones any nonzero product carries again, so it stays pinned.
      acc_nxt = carry ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
      acc_nxt = sum_ext[AW-1:0];
`endif
      ovf_nxt    = ovf | carry;
      cnt_nxt    = cnt + CW'(1);
      // Only meaningful when qualified by an input handshake.
      close_cond = (cnt_nxt == CW'(N_ACC)) || in_last;
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // in_ready is decoded from state and reset only, so it is low throughout reset.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACC: begin
            in_ready = !reset;
            if (in_valid && !reset && close_cond) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ACC;
            end
         end
         default: begin
            state_nxt = ACC;
         end
      endcase
   end

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   // ------------------------------------------------------------------
   // Accumulator and result registers
   // ------------------------------------------------------------------
   // The internal accumulator keeps the final group value through HOLD and only
   // clears on the output handshake; input handshakes cannot happen in HOLD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_cnt <= '0;
         out_ovf <= 1'b0;
      end else if (in_hs) begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
         if (close_cond) begin
            out_sum <= acc_nxt;
            out_cnt <= cnt_nxt;
            out_ovf <= ovf_nxt;
         end
      end else if (out_hs) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: directed checks of mul_acc (default parameters) plus an AW=9 instance for
//   overflow and a randomised run against a reference model of the group sums.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_mul_acc;

   localparam int CW = 3;

   logic          clk;
   logic          reset;

   // Instance A: default parameters
   logic          a_in_valid;
   logic          a_in_ready;
   logic [7:0]    a_in_prod;
   logic          a_in_last;
   logic          a_out_valid;
   logic          a_out_ready;
   logic [15:0]   a_out_sum;
   logic [CW-1:0] a_out_cnt;
   logic          a_out_ovf;

   // Instance B: AW=9 so overflow is reachable
   logic          b_in_valid;
   logic          b_in_ready;
   logic [7:0]    b_in_prod;
   logic          b_in_last;
   logic          b_out_valid;
   logic          b_out_ready;
   logic [8:0]    b_out_sum;
   logic [CW-1:0] b_out_cnt;
   logic          b_out_ovf;

   int n_cmp;
   int n_bad;

   mul_acc u_a (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_prod   (a_in_prod),
      .in_last   (a_in_last),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_sum   (a_out_sum),
      .out_cnt   (a_out_cnt),
      .out_ovf   (a_out_ovf)
   );

   mul_acc #(.PW(8), .AW(9), .N_ACC(4)) u_b (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_prod   (b_in_prod),
      .in_last   (b_in_last),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_sum   (b_out_sum),
      .out_cnt   (b_out_cnt),
      .out_ovf   (b_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one product into instance A for one cycle.
   task automatic a_push(input logic [7:0] p, input logic last);
      a_in_valid = 1'b1;
      a_in_prod  = p;
      a_in_last  = last;
      tick();
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      a_in_prod  = '0;
   endtask

   // Reference model state for the random run on instance B
   int m_acc, m_cnt, m_ovf, m_hold;
   int r_sum, r_cnt, r_ovf;
   int groups, tot_dut, tot_mod, s;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      a_in_valid = 0; a_in_prod = 0; a_in_last = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_prod = 0; b_in_last = 0; b_out_ready = 1;
      tick();
      tick();

      // ---------------- reset state ----------------
      chk("rst_in_ready",  32'(a_in_ready),  0);
      chk("rst_out_valid", 32'(a_out_valid), 0);
      chk("rst_out_sum",   32'(a_out_sum),   0);
      chk("rst_out_cnt",   32'(a_out_cnt),   0);
      chk("rst_out_ovf",   32'(a_out_ovf),   0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(a_in_ready), 1);
      tick();

      // ---------------- sum to limit: 10+20+30+40 ----------------
      a_push(8'd10, 0);
      a_push(8'd20, 0);
      a_push(8'd30, 0);
      chk("lim_no_early_valid", 32'(a_out_valid), 0);
      a_push(8'd40, 0);
      chk("lim_valid",    32'(a_out_valid), 1);
      chk("lim_sum",      32'(a_out_sum),   100);
      chk("lim_cnt",      32'(a_out_cnt),   4);
      chk("lim_ovf",      32'(a_out_ovf),   0);
      chk("lim_in_ready", 32'(a_in_ready),  0);
      tick();
      chk("lim_valid_1cyc", 32'(a_out_valid), 0);
      chk("lim_sum_kept",   32'(a_out_sum),   100);
      chk("lim_in_ready2",  32'(a_in_ready),  1);

      // ---------------- early close: 5, 7(last) ----------------
      a_push(8'd5, 0);
      a_push(8'd7, 1);
      chk("early_valid", 32'(a_out_valid), 1);
      chk("early_sum",   32'(a_out_sum),   12);
      chk("early_cnt",   32'(a_out_cnt),   2);
      tick();
      a_push(8'd3, 1);
      chk("clean_sum", 32'(a_out_sum), 3);
      chk("clean_cnt", 32'(a_out_cnt), 1);
      tick();

      // ---------------- backpressure ----------------
      a_out_ready = 1'b0;
      a_push(8'd1, 0);
      a_push(8'd2, 0);
      a_push(8'd3, 0);
      a_push(8'd4, 0);
      for (int i = 0; i < 5; i++) begin
         a_in_valid = (i == 2);
         a_in_prod  = (i == 2) ? 8'd99 : 8'd0;
         a_in_last  = (i == 2);
         chk("bp_valid",    32'(a_out_valid), 1);
         chk("bp_sum",      32'(a_out_sum),   10);
         chk("bp_cnt",      32'(a_out_cnt),   4);
         chk("bp_in_ready", 32'(a_in_ready),  0);
         tick();
      end
      a_in_valid = 0; a_in_last = 0; a_in_prod = 0;
      a_out_ready = 1'b1;
      tick();
      chk("bp_released", 32'(a_out_valid), 0);
      a_push(8'd6, 1);
      chk("bp_next_sum", 32'(a_out_sum), 6);
      chk("bp_next_cnt", 32'(a_out_cnt), 1);
      tick();

      // ---------------- overflow on AW=9 instance ----------------
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1; b_in_prod = 8'd255; b_in_last = (i == 2);
         tick();
      end
      b_in_valid = 0; b_in_last = 0; b_in_prod = 0;
      chk("ovf_valid", 32'(b_out_valid), 1);
`ifdef MUL_ACC_SAT_EN
      chk("ovf_sum", 32'(b_out_sum), 511);
`else
      chk("ovf_sum", 32'(b_out_sum), 253);
`endif
      chk("ovf_flag", 32'(b_out_ovf), 1);
      chk("ovf_cnt",  32'(b_out_cnt), 3);
      tick();
      // next group on B starts with ovf cleared
      b_in_valid = 1; b_in_prod = 8'd1; b_in_last = 1;
      tick();
      b_in_valid = 0; b_in_last = 0; b_in_prod = 0;
      chk("ovf_cleared_sum", 32'(b_out_sum), 1);
      chk("ovf_cleared_flg", 32'(b_out_ovf), 0);
      tick();

      // ---------------- reset mid-group ----------------
      a_push(8'd50, 0);
      a_push(8'd60, 0);
      reset = 1'b1;
      #2;
      chk("mrst_in_ready",  32'(a_in_ready),  0);
      chk("mrst_out_valid", 32'(a_out_valid), 0);
      chk("mrst_out_sum",   32'(a_out_sum),   0);
      chk("mrst_out_cnt",   32'(a_out_cnt),   0);
      chk("mrst_out_ovf",   32'(a_out_ovf),   0);
      tick();
      reset = 1'b0;
      tick();
      a_push(8'd1, 0);
      a_push(8'd2, 0);
      a_push(8'd3, 0);
      a_push(8'd4, 0);
      chk("mrst_valid", 32'(a_out_valid), 1);
      chk("mrst_sum",   32'(a_out_sum),   10);
      chk("mrst_cnt",   32'(a_out_cnt),   4);
      tick();

      // ---------------- random stress on instance B ----------------
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
      r_sum = 0; r_cnt = 0; r_ovf = 0;
      groups = 0; tot_dut = 0; tot_mod = 0;
      for (int c = 0; c < 400; c++) begin
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_in_prod   = 8'($urandom_range(0, 255));
         b_in_last   = ($urandom_range(0, 3) == 0);
         b_out_ready = ($urandom_range(0, 2) != 0);
         #1;
         chk("rnd_out_valid", 32'(b_out_valid), 32'(m_hold));
         chk("rnd_in_ready",  32'(b_in_ready),  32'(m_hold == 0));
         if (m_hold != 0) begin
            if (b_out_ready) begin
               chk("rnd_sum", 32'(b_out_sum), 32'(r_sum));
               chk("rnd_cnt", 32'(b_out_cnt), 32'(r_cnt));
               chk("rnd_ovf", 32'(b_out_ovf), 32'(r_ovf));
               groups++;
               tot_dut += int'(b_out_cnt);
               tot_mod += r_cnt;
               m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
            end
         end else if (b_in_valid) begin
            s = m_acc + int'(b_in_prod);
            if (s > 511) begin
               m_ovf = 1;
`ifdef MUL_ACC_SAT_EN
               s = 511;
`else
               s = s - 512;
`endif
            end
            m_acc = s;
            m_cnt++;
            if (m_cnt == 4 || b_in_last) begin
               m_hold = 1;
               r_sum = m_acc; r_cnt = m_cnt; r_ovf = m_ovf;
            end
         end
         tick();
      end
      b_in_valid = 0;
      chk("rnd_terms_total", 32'(tot_dut), 32'(tot_mod));
      chk("rnd_some_groups", 32'(groups > 20), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
